// File: rtl/byte_pair_pkg.sv
// Shared definitions for the byte pair assembler and its neighbours
// (UART receiver and the two-byte display/command decoder).
package byte_pair_pkg;

  // Assembler FSM states
  typedef enum logic {
    IDLE        = 1'b0,
    WAIT_SECOND = 1'b1
  } pairStateT;

  // Command bytes understood by the downstream decoder
  localparam logic [7:0] CMD_DIGIT_1 = 8'h31;
  localparam logic [7:0] CMD_P       = 8'h50;

  // One second at a 50 MHz system clock
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd50_000_000;

endpackage

// File: rtl/byte_pair_timer.sv
// Loadable saturating up-counter with synchronous clear and a
// terminal-count flag. Clear has priority over load, load over count.
// The counter stops at TERMINAL so it can never wrap.
module byte_pair_timer #(
  parameter int              CNT_W    = 32,
  parameter logic [CNT_W-1:0] TERMINAL = '1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  output logic             atTerminal
);

  logic [CNT_W-1:0] count;

  // Counter register: clear, load, or count up until the terminal value
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (enable && (count != TERMINAL)) begin
      count <= count + 1'b1;
    end
  end

  assign atTerminal = (count == TERMINAL);

endmodule

// File: rtl/byte_pair_assembler.sv
// Collects two consecutive UART bytes into a command/data pair and holds
// the last completed pair on registered outputs for the decoder.
// A half pair is dropped if the second byte does not arrive in time.
// Optional macro BYTE_PAIR_CMD_CHECK_EN: rejects first bytes outside
// [CMD_MIN, CMD_MAX] and reports them on the cmd_err pulse output.
module byte_pair_assembler
  import byte_pair_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int          CNT_W          = 32
`ifdef BYTE_PAIR_CMD_CHECK_EN
  ,
  parameter logic [7:0]  CMD_MIN        = 8'h30,
  parameter logic [7:0]  CMD_MAX        = 8'h5A
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] first_byte,
  output logic [7:0] second_byte,
  output logic       pair_valid,
  output logic       busy,
`ifdef BYTE_PAIR_CMD_CHECK_EN
  output logic       cmd_err,
`endif
  output logic       timeout_err
);

  // The timer reaches TERMINAL on the cycle the timeout would fire
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

  pairStateT  state, nextState;
  logic [7:0] holdReg, holdNext;
  logic [7:0] firstNext, secondNext;
  logic       pairNext, timeoutNext, cmdErrNext, busyNext;
  logic       cmdOk;
  logic       timerClear, timerAtTerminal;

  byte_pair_timer #(
    .CNT_W    (CNT_W),
    .TERMINAL (TERMINAL)
  ) uTimer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (timerClear),
    .enable     (1'b1),
    .load       (1'b0),
    .loadValue  ('0),
    .atTerminal (timerAtTerminal)
  );

  // Decide whether an incoming byte may start a new pair
  always_comb begin
`ifdef BYTE_PAIR_CMD_CHECK_EN
    cmdOk = (rx_data >= CMD_MIN) && (rx_data <= CMD_MAX);
`else
    cmdOk = 1'b1;
`endif
  end

  // Next-state and next-output logic; a byte always beats the timeout
  always_comb begin
    nextState   = state;
    holdNext    = holdReg;
    firstNext   = first_byte;
    secondNext  = second_byte;
    pairNext    = 1'b0;
    timeoutNext = 1'b0;
    cmdErrNext  = 1'b0;
    timerClear  = 1'b1;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (cmdOk) begin
            holdNext  = rx_data;
            nextState = WAIT_SECOND;
          end else begin
            cmdErrNext = 1'b1;
          end
        end
      end
      WAIT_SECOND: begin
        if (rx_valid) begin
          firstNext  = holdReg;
          secondNext = rx_data;
          pairNext   = 1'b1;
          nextState  = IDLE;
        end else if (timerAtTerminal) begin
          timeoutNext = 1'b1;
          nextState   = IDLE;
        end else begin
          timerClear = 1'b0;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    busyNext = (nextState == WAIT_SECOND);
  end

  // State, holding register and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      holdReg     <= 8'h00;
      first_byte  <= 8'h00;
      second_byte <= 8'h00;
      pair_valid  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef BYTE_PAIR_CMD_CHECK_EN
      cmd_err     <= 1'b0;
`endif
    end else begin
      state       <= nextState;
      holdReg     <= holdNext;
      first_byte  <= firstNext;
      second_byte <= secondNext;
      pair_valid  <= pairNext;
      busy        <= busyNext;
      timeout_err <= timeoutNext;
`ifdef BYTE_PAIR_CMD_CHECK_EN
      cmd_err     <= cmdErrNext;
`endif
    end
  end

`ifndef BYTE_PAIR_CMD_CHECK_EN
  // cmdErrNext only drives a port when the command check is built in
  logic unusedCmdErr;
  assign unusedCmdErr = cmdErrNext;
`endif

endmodule

// File: tb/tb_byte_pair_assembler.sv
// Directed bench for byte_pair_assembler with a short timeout of 16 cycles.
// Define BYTE_PAIR_CMD_CHECK_EN to also exercise command range checking.
module tb_byte_pair_assembler;

  localparam int unsigned TB_TIMEOUT = 16;

  logic       clock;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] first_byte;
  logic [7:0] second_byte;
  logic       pair_valid;
  logic       busy;
  logic       timeout_err;
`ifdef BYTE_PAIR_CMD_CHECK_EN
  logic       cmd_err;
`endif

  int checks = 0;
  int errors = 0;

  byte_pair_assembler #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .CNT_W          (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .first_byte  (first_byte),
    .second_byte (second_byte),
    .pair_valid  (pair_valid),
    .busy        (busy),
`ifdef BYTE_PAIR_CMD_CHECK_EN
    .cmd_err     (cmd_err),
`endif
    .timeout_err (timeout_err)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value with its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, take the edge, then sample just after it
  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    @(negedge clock);
    rx_valid = valid;
    rx_data  = data;
    @(posedge clock);
    #1;
  endtask

  // Synchronous-release reset pulse
  task automatic doReset();
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset_n  = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // ---- Test 1: reset state, then 8'h50 / 8'h31 five cycles apart
    $display("[TB] test 1: basic pair");
    #12;
    checkOutput("rst_first", first_byte, 8'h00);
    checkOutput("rst_second", second_byte, 8'h00);
    checkOutput("rst_pair", {7'd0, pair_valid}, 8'h00);
    checkOutput("rst_busy", {7'd0, busy}, 8'h00);
    checkOutput("rst_tmo", {7'd0, timeout_err}, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b1, 8'h50);
    checkOutput("t1_busy0", {7'd0, busy}, 8'h01);
    checkOutput("t1_first_held", first_byte, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput("t1_busy_wait", {7'd0, busy}, 8'h01);
      checkOutput("t1_pair_wait", {7'd0, pair_valid}, 8'h00);
    end
    applyStimulus(1'b1, 8'h31);
    checkOutput("t1_pair", {7'd0, pair_valid}, 8'h01);
    checkOutput("t1_first", first_byte, 8'h50);
    checkOutput("t1_second", second_byte, 8'h31);
    checkOutput("t1_busy_end", {7'd0, busy}, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1_pair_once", {7'd0, pair_valid}, 8'h00);
    checkOutput("t1_first_hold", first_byte, 8'h50);

    // ---- Test 2: timeout after a lone 8'h41, then a normal pair
    $display("[TB] test 2: timeout");
    doReset();
    applyStimulus(1'b1, 8'h41);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("t2_tmo_%0d", k), {7'd0, timeout_err},
                  (k == 16) ? 8'h01 : 8'h00);
      checkOutput($sformatf("t2_busy_%0d", k), {7'd0, busy},
                  (k < 16) ? 8'h01 : 8'h00);
    end
    checkOutput("t2_first_keep", first_byte, 8'h00);
    checkOutput("t2_second_keep", second_byte, 8'h00);
    checkOutput("t2_pair_none", {7'd0, pair_valid}, 8'h00);
    applyStimulus(1'b1, 8'h50);
    applyStimulus(1'b1, 8'h31);
    checkOutput("t2_pair", {7'd0, pair_valid}, 8'h01);
    checkOutput("t2_first", first_byte, 8'h50);
    checkOutput("t2_second", second_byte, 8'h31);

    // ---- Test 3: four back-to-back strobes
    $display("[TB] test 3: back-to-back pairs");
    applyStimulus(1'b1, 8'h50);
    checkOutput("t3_pair_a", {7'd0, pair_valid}, 8'h00);
    applyStimulus(1'b1, 8'h31);
    checkOutput("t3_pair_b", {7'd0, pair_valid}, 8'h01);
    checkOutput("t3_first_b", first_byte, 8'h50);
    checkOutput("t3_second_b", second_byte, 8'h31);
    applyStimulus(1'b1, 8'h31);
    checkOutput("t3_pair_c", {7'd0, pair_valid}, 8'h00);
    checkOutput("t3_busy_c", {7'd0, busy}, 8'h01);
    applyStimulus(1'b1, 8'h50);
    checkOutput("t3_pair_d", {7'd0, pair_valid}, 8'h01);
    checkOutput("t3_first_d", first_byte, 8'h31);
    checkOutput("t3_second_d", second_byte, 8'h50);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t3_pair_e", {7'd0, pair_valid}, 8'h00);

    // ---- Test 4: second byte on the exact cycle the timeout would fire
    $display("[TB] test 4: byte beats timeout");
    applyStimulus(1'b1, 8'h50);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("t4_busy_pre", {7'd0, busy}, 8'h01);
    checkOutput("t4_tmo_pre", {7'd0, timeout_err}, 8'h00);
    applyStimulus(1'b1, 8'h31);
    checkOutput("t4_pair", {7'd0, pair_valid}, 8'h01);
    checkOutput("t4_tmo", {7'd0, timeout_err}, 8'h00);
    checkOutput("t4_first", first_byte, 8'h50);
    checkOutput("t4_second", second_byte, 8'h31);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4_tmo_after", {7'd0, timeout_err}, 8'h00);

    // ---- Test 5: reset mid-pair clears outputs asynchronously
    $display("[TB] test 5: reset mid-pair");
    applyStimulus(1'b1, 8'h50);
    checkOutput("t5_busy_pre", {7'd0, busy}, 8'h01);
    rx_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("t5_busy_rst", {7'd0, busy}, 8'h00);
    checkOutput("t5_first_rst", first_byte, 8'h00);
    checkOutput("t5_second_rst", second_byte, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b1, 8'h31);
    checkOutput("t5_pair_a", {7'd0, pair_valid}, 8'h00);
    checkOutput("t5_busy_a", {7'd0, busy}, 8'h01);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t5_pair_b", {7'd0, pair_valid}, 8'h00);
    checkOutput("t5_first_b", first_byte, 8'h00);

`ifdef BYTE_PAIR_CMD_CHECK_EN
    // ---- Test 6: out-of-range command byte rejected
    $display("[TB] test 6: command check");
    doReset();
    applyStimulus(1'b1, 8'h07);
    checkOutput("t6_cmderr", {7'd0, cmd_err}, 8'h01);
    checkOutput("t6_busy", {7'd0, busy}, 8'h00);
    applyStimulus(1'b1, 8'h50);
    checkOutput("t6_cmderr_clr", {7'd0, cmd_err}, 8'h00);
    checkOutput("t6_busy_wait", {7'd0, busy}, 8'h01);
    applyStimulus(1'b1, 8'h31);
    checkOutput("t6_pair", {7'd0, pair_valid}, 8'h01);
    checkOutput("t6_first", first_byte, 8'h50);
    checkOutput("t6_second", second_byte, 8'h31);
    checkOutput("t6_cmderr_end", {7'd0, cmd_err}, 8'h00);
`endif

    applyStimulus(1'b0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_pair_assembler.md
Name: byte_pair_assembler

Overview:
- Sits between the UART receiver and the two-byte display/command decoder.
- Collects two consecutive received bytes into a command/data pair.
- Holds the completed pair stable on registered outputs for the combinational decoder and signals completion with a one-cycle strobe.
- Discards a half-received pair if the second byte does not arrive within a timeout, so the next byte is taken as a fresh first byte.

Parameters:
- TIMEOUT_CYCLES, 50000000, max clock cycles waited for the second byte (1 s at 50 MHz); legal range 2..2^32-1.
- CNT_W, 32, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- CMD_MIN, 8'h30, lowest accepted first byte (used only with the optional feature).
- CMD_MAX, 8'h5A, highest accepted first byte (used only with the optional feature).

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- first_byte  out  8  latched command byte of the last completed pair.
- second_byte  out  8  latched data byte of the last completed pair.
- pair_valid  out  1  one-cycle pulse when first_byte/second_byte update.
- busy  out  1  high while waiting for the second byte.
- timeout_err  out  1  one-cycle pulse when a half pair is discarded.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - first_byte = 8'h00, second_byte = 8'h00; the decoder then shows blank.
  - pair_valid = 0, busy = 0, timeout_err = 0.
  - State = IDLE, counter = 0, internal first-byte holding register = 0.
- FSM has two states, IDLE and WAIT_SECOND.
- IDLE:
  - rx_valid = 1: store rx_data in the holding register, clear the counter, go to WAIT_SECOND.
  - first_byte is not changed in this cycle.
- WAIT_SECOND:
  - rx_valid = 1: first_byte <= holding register and second_byte <= rx_data, both in the same edge. pair_valid = 1 for exactly the next cycle. Go to IDLE.
  - rx_valid = 0: the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without a byte, go to IDLE, pulse timeout_err for 1 cycle, and leave outputs unchanged.
- Simultaneous events:
  - rx_valid in the same cycle the timeout would fire: the byte wins. The pair completes and no timeout_err is raised.
  - rx_valid in the cycle after pair completion (state already IDLE): accepted as a new first byte, so back-to-back pairs need no gap.
- Latency: pair_valid and the updated outputs appear 1 cycle after the second rx_valid.
- Output behaviour:
  - busy is registered and equals (state == WAIT_SECOND).
  - first_byte/second_byte change only on pair completion; they are held indefinitely otherwise.
- Reset mid-pair: the partial byte is discarded, and outputs return to reset values immediately (asynchronously).
- Counter never wraps; it is held at 0 in IDLE.

Optional Feature:
- Macro: BYTE_PAIR_CMD_CHECK_EN.
- Defined:
  - In IDLE, a byte outside [CMD_MIN, CMD_MAX] is rejected. State stays IDLE and a one-cycle cmd_err output pulse is asserted (port cmd_err, out, 1; exists only when defined).
  - This keeps the assembler resynchronised if a data byte is mistaken for a command.
- Undefined: every byte is accepted as a first byte; the cmd_err port is absent.

Decomposition:
- Shared package byte_pair_pkg holds:
  - state enum (IDLE = 1'b0, WAIT_SECOND = 1'b1);
  - command byte constants CMD_DIGIT_1 = 8'h31 and CMD_P = 8'h50 (also used by the decoder);
  - default TIMEOUT_CYCLES.
- Optional sub-module byte_pair_timer: loadable up-counter with clear and terminal-count output, reusable by the UART RX.
- The FSM and output registers stay in the top block.

Test Plan:
1. Reset, then rx 8'h50 then 8'h31, 5 cycles apart: first_byte = 8'h50, second_byte = 8'h31, one pair_valid pulse 1 cycle after the second strobe, busy high for 5 cycles.
2. TIMEOUT_CYCLES = 16, send one byte 8'h41 and wait 20 cycles: timeout_err pulses exactly once (16 cycles after the strobe), busy falls, outputs unchanged at 8'h00. Then send 8'h50, 8'h31: pair completes normally.
3. Four back-to-back strobes 8'h50, 8'h31, 8'h31, 8'h50 on consecutive cycles: two pair_valid pulses; final outputs are 8'h31/8'h50.
4. Second byte arrives in exactly cycle TIMEOUT_CYCLES-1: pair completes and timeout_err stays 0.
5. Assert reset_n low mid-pair (after first byte 8'h50): outputs and busy clear immediately. After release, a single byte 8'h31 does not produce pair_valid.
6. With BYTE_PAIR_CMD_CHECK_EN, send 8'h07 then 8'h50, 8'h31: cmd_err pulses once for 8'h07, busy stays 0, then the pair 8'h50/8'h31 completes.
